// File: rtl/tl_controller.sv
// Highway / farm-road traffic-light sequencer driven by the interval timer's
// long/short timeout pulses; issues timer restart requests and light heads.
module tl_controller #(
  parameter int FARM_EXT_MAX = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car,
  input  logic       long_to,
  input  logic       short_to,
  output logic       start_long,
  output logic       start_short,
  output logic [1:0] hwy_light,
  output logic [1:0] farm_light,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    HG = 2'b00,
    HY = 2'b01,
    FG = 2'b10,
    FY = 2'b11
  } state_t;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [2:0] EXT_MAX = 3'(FARM_EXT_MAX);

  state_t     state, state_n;
  logic       long_done, long_done_n;
  logic [2:0] ext_cnt, ext_cnt_n;
  logic       init, init_n;
  logic       start_long_n, start_short_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HG;
      long_done   <= 1'b0;
      ext_cnt     <= 3'd0;
      init        <= 1'b1;
      start_long  <= 1'b0;
      start_short <= 1'b0;
    end else begin
      state       <= state_n;
      long_done   <= long_done_n;
      ext_cnt     <= ext_cnt_n;
      init        <= init_n;
      start_long  <= start_long_n;
      start_short <= start_short_n;
    end
  end

  // The first cycle after reset only arms the timer; no timeout can be
  // pending yet, so the state machine proper waits one cycle.
  always_comb begin
    state_n       = state;
    long_done_n   = long_done;
    ext_cnt_n     = ext_cnt;
    init_n        = init;
    start_long_n  = 1'b0;
    start_short_n = 1'b0;
    if (init) begin
      init_n       = 1'b0;
      start_long_n = 1'b1;
    end else begin
      unique case (state)
        HG: begin
          long_done_n = long_done | long_to;
          if ((long_done | long_to) && car) begin
            state_n       = HY;
            start_short_n = 1'b1;
          end
        end
        HY: begin
          if (short_to) begin
            state_n      = FG;
            start_long_n = 1'b1;
            ext_cnt_n    = 3'd0;
          end
        end
        FG: begin
          if (long_to) begin
            if (!car || ext_cnt == EXT_MAX) begin
              state_n       = FY;
              start_short_n = 1'b1;
            end else begin
              ext_cnt_n    = ext_cnt + 3'd1;
              start_long_n = 1'b1;
            end
          end
        end
        FY: begin
          if (short_to) begin
            state_n      = HG;
            start_long_n = 1'b1;
            long_done_n  = 1'b0;
          end
        end
        default: state_n = HG;
      endcase
    end
  end

  // Lights are a pure decode of the state register, so they switch with state_o.
  always_comb begin
    hwy_light  = RED;
    farm_light = RED;
    unique case (state)
      HG:      hwy_light  = GREEN;
      HY:      hwy_light  = YELLOW;
      FG:      farm_light = GREEN;
      FY:      farm_light = YELLOW;
      default: hwy_light  = RED;
    endcase
  end

  assign state_o = state;

endmodule
